axis_s_packer: RTL and testbench
================================

AXIS_S_PACKER -- requirements
Module: axis_s_packer

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, output word width in bits (multiple of 8, >=16); BYTES = DATA_W/8.
REQ-002 SHALL provide parameter OUT_DEPTH, default 4, output buffer depth in words (power of 2, >=2).
REQ-003 SHALL provide parameter FLUSH_TIMEOUT, default 16, idle cycles before a partial word is flushed (0 disables flushing).
REQ-004 s_axis_aclk  input  1  clock; all logic on rising edge.
REQ-005 s_axis_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_from_fifo  input  8  byte from the upstream FIFO; first-word-fall-through, valid whenever r_empty=0.
REQ-007 i_last  input  1  sideband qualifying i_from_fifo; marks the final byte of a packet.
REQ-008 r_empty  input  1  upstream FIFO empty.
REQ-009 r_req  output  1  byte consume strobe; a byte is taken on each edge where r_req=1.
REQ-010 s_axis_tdata  output  DATA_W  stream data.
REQ-011 s_axis_tkeep  output  BYTES  byte-lane qualifiers.
REQ-012 s_axis_tlast  output  1  end of packet.
REQ-013 s_axis_valid  output  1  stream valid.
REQ-014 s_axis_ready  input  1  downstream ready.
REQ-015 o_level  output  $clog2(OUT_DEPTH)+1  output buffer occupancy, 0..OUT_DEPTH.

Function
REQ-016 r_req SHALL be combinational: 1 iff r_empty=0, output buffer not full, and not in reset.
REQ-017 SHALL pack bytes little-endian: byte at lane k goes to bits [8k+7:8k]; lane counter starts at 0 and increments per consumed byte.
REQ-018 A word SHALL complete on the edge consuming a byte at lane BYTES-1 or a byte with i_last=1, whichever comes first.
REQ-019 On completion, word, tkeep and tlast SHALL be pushed into the output buffer at that same edge and the lane counter SHALL return to 0.
REQ-020 tkeep SHALL be contiguous ones in lanes 0..n-1 for n valid bytes; unused lanes SHALL carry data 0.
REQ-021 tlast SHALL equal 1 iff the completing byte had i_last=1.
REQ-022 Idle counter SHALL count consecutive cycles with lane>0 and r_req=0, clearing on any consumed byte or when lane=0.
REQ-023 When FLUSH_TIMEOUT>0, lane>0, idle counter = FLUSH_TIMEOUT and buffer not full, the partial word SHALL be pushed with tlast=0 and the lane counter reset to 0.
REQ-024 If the buffer is full at timeout, flush SHALL wait, holding the counter, until a slot frees.
REQ-025 Output buffer SHALL be FIFO-ordered, first-word-fall-through; s_axis_valid = (o_level != 0).
REQ-026 Latency: word completed at edge N SHALL be visible with s_axis_valid=1 after edge N when the buffer was empty.
REQ-027 A transfer SHALL occur on each edge with s_axis_valid=1 and s_axis_ready=1; tdata/tkeep/tlast SHALL be held stable while valid=1 and ready=0.
REQ-028 Simultaneous push and pop SHALL leave o_level unchanged; pointers SHALL wrap modulo OUT_DEPTH.
REQ-029 No push SHALL occur when full and no pop when empty; no byte SHALL be dropped or duplicated.
REQ-030 Sustained throughput SHALL be one byte per cycle whenever upstream is non-empty and downstream is ready.

Reset
REQ-031 While s_axis_reset_n=0: s_axis_valid=0, s_axis_tdata=0, s_axis_tkeep=0, s_axis_tlast=0, r_req=0, o_level=0.
REQ-032 Reset SHALL clear lane counter, idle counter and buffer pointers; a partial word or buffered words present at reset SHALL be discarded.
REQ-033 After deassertion, the first consumed byte SHALL land in lane 0.

Verification (DATA_W=32, OUT_DEPTH=4, FLUSH_TIMEOUT=16)
REQ-034 Bytes 11,22,33,44 with i_last=0 on last, ready=1 -> one beat tdata=0x44332211, tkeep=0xF, tlast=0, one cycle after the fourth byte.
REQ-035 Bytes AA,BB with i_last=1 on BB -> tdata=0x0000BBAA, tkeep=0x3, tlast=1.
REQ-036 Byte 5A then upstream empty for 16 cycles -> tdata=0x0000005A, tkeep=0x1, tlast=0; next byte lands in lane 0.
REQ-037 ready=0 while streaming 20 bytes -> o_level reaches 4, r_req falls to 0 with 16 bytes consumed; ready=1 -> all 5 words emitted in order, no loss.
REQ-038 Reset asserted after 2 bytes of a word and with 2 words buffered -> all outputs 0 immediately; after release, new bytes 01..04 -> 0x04030201, tkeep=0xF.
REQ-039 Random upstream gaps and random ready over 10k bytes with random i_last -> scoreboard byte-exact match, tkeep/tlast correct, tdata stable under backpressure.

Source files
------------

// File: rtl/axis_s_packer.sv
// axis_s_packer: packs a byte stream from a first-word-fall-through FIFO into
//   little-endian AXI-Stream words, with tkeep/tlast and an idle-timeout flush.
// Latency: a word completed on edge N is presented (s_axis_valid=1) right after
//   edge N when the output buffer was empty.
// Backpressure: s_axis_ready=0 fills the OUT_DEPTH-word buffer; once it is full,
//   r_req drops and upstream bytes wait in the source FIFO.
//
// Ports:
//   s_axis_aclk, s_axis_reset_n   clock, async active-low reset
//   i_from_fifo, i_last, r_empty  upstream FWFT byte, end-of-packet flag, empty
//   r_req                         byte consume strobe (combinational)
//   s_axis_tdata/tkeep/tlast      output word, lane qualifiers, end of packet
//   s_axis_valid, s_axis_ready    output handshake
//   o_level                       output buffer occupancy, 0..OUT_DEPTH

// Generic first-word-fall-through FIFO used as the packer's output buffer.
// Latency: a word written on edge N is readable right after edge N.
// Backpressure: wr_vld is ignored while full; rd_rdy is ignored while empty.
module axis_s_packer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    output logic                       full,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full   = (level == LVL_W'(DEPTH));
    assign rd_vld = (level != '0);
    assign push   = wr_vld & ~full;
    assign pop    = rd_rdy & rd_vld;
    assign rd_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Storage needs no reset: the read side is only meaningful while level != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end
endmodule

module axis_s_packer #(
    parameter int DATA_W        = 32,
    parameter int OUT_DEPTH     = 4,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                         s_axis_aclk,
    input  logic                         s_axis_reset_n,
    input  logic [7:0]                   i_from_fifo,
    input  logic                         i_last,
    input  logic                         r_empty,
    output logic                         r_req,
    output logic [DATA_W-1:0]            s_axis_tdata,
    output logic [DATA_W/8-1:0]          s_axis_tkeep,
    output logic                         s_axis_tlast,
    output logic                         s_axis_valid,
    input  logic                         s_axis_ready,
    output logic [$clog2(OUT_DEPTH):0]   o_level
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    typedef struct packed {
        logic              last;
        logic [BYTES-1:0]  keep;
        logic [DATA_W-1:0] dat;
    } beat_t;

    logic [LANE_W-1:0] lane;        // next lane to fill
    logic [DATA_W-1:0] acc_dat;     // lanes below 'lane' hold collected bytes, the rest are 0
    logic [IDLE_W-1:0] idle_cnt;
    logic              buf_full;
    logic              take;
    logic              word_done;
    logic              flush_fire;
    logic              push_vld;
    beat_t             push_beat;
    beat_t             pop_beat;
    logic [DATA_W-1:0] merged_dat;
    logic [BYTES-1:0]  keep_incl;   // lanes 0..lane
    logic [BYTES-1:0]  keep_excl;   // lanes 0..lane-1

    assign r_req = s_axis_reset_n & ~r_empty & ~buf_full;
    assign take  = r_req;

    assign word_done = take & (i_last | (lane == LANE_W'(BYTES - 1)));

    // A byte arriving on the very cycle the timeout matures is appended to the
    // partial word instead of being raced against the flush; the idle count
    // restarts from that byte.
    assign flush_fire = (FLUSH_TIMEOUT > 0) & (lane != '0) & ~take & ~buf_full
                      & (idle_cnt == IDLE_W'(FLUSH_TIMEOUT));

    assign push_vld = word_done | flush_fire;

    always_comb begin
        merged_dat = acc_dat;
        keep_incl  = '0;
        keep_excl  = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (lane == LANE_W'(k)) begin
                merged_dat[8*k +: 8] = i_from_fifo;
            end
            keep_incl[k] = (LANE_W'(k) <= lane);
            keep_excl[k] = (LANE_W'(k) <  lane);
        end
    end

    always_comb begin
        push_beat = '0;
        if (word_done) begin
            push_beat.dat  = merged_dat;
            push_beat.keep = keep_incl;
            push_beat.last = i_last;
        end else if (flush_fire) begin
            push_beat.dat  = acc_dat;
            push_beat.keep = keep_excl;
            push_beat.last = 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
        if (!s_axis_reset_n) begin
            lane     <= '0;
            acc_dat  <= '0;
            idle_cnt <= '0;
        end else begin
            if (word_done || flush_fire) begin
                lane    <= '0;
                acc_dat <= '0;
            end else if (take) begin
                lane    <= lane + LANE_W'(1);
                acc_dat <= merged_dat;
            end

            // Saturating at the timeout value holds a due flush while the
            // buffer is full.
            if (take || (lane == '0) || flush_fire) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(FLUSH_TIMEOUT)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    axis_s_packer_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_buf (
        .clk    (s_axis_aclk),
        .arst_n (s_axis_reset_n),
        .wr_vld (push_vld),
        .wr_dat (push_beat),
        .full   (buf_full),
        .rd_rdy (s_axis_ready),
        .rd_vld (s_axis_valid),
        .rd_dat (pop_beat),
        .level  (o_level)
    );

    // Gate with valid so an empty (or resetting) buffer presents all zeros.
    assign s_axis_tdata = s_axis_valid ? pop_beat.dat  : '0;
    assign s_axis_tkeep = s_axis_valid ? pop_beat.keep : '0;
    assign s_axis_tlast = s_axis_valid ? pop_beat.last : 1'b0;
endmodule

// File: tb/tb_axis_s_packer.sv
`timescale 1ns/1ps
module tb_axis_s_packer;
    localparam int DATA_W        = 32;
    localparam int BYTES         = 4;
    localparam int OUT_DEPTH     = 4;
    localparam int FLUSH_TIMEOUT = 16;

    logic        s_axis_aclk = 1'b0;
    logic        s_axis_reset_n;
    logic [7:0]  i_from_fifo;
    logic        i_last;
    logic        r_empty;
    logic        r_req;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic [2:0]  o_level;

    axis_s_packer #(
        .DATA_W        (DATA_W),
        .OUT_DEPTH     (OUT_DEPTH),
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) dut (
        .s_axis_aclk    (s_axis_aclk),
        .s_axis_reset_n (s_axis_reset_n),
        .i_from_fifo    (i_from_fifo),
        .i_last         (i_last),
        .r_empty        (r_empty),
        .r_req          (r_req),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_valid   (s_axis_valid),
        .s_axis_ready   (s_axis_ready),
        .o_level        (o_level)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    // Entries are {last, byte}.
    logic [8:0] src_q[$];   // upstream FIFO contents not yet consumed
    logic [8:0] exp_q[$];   // consumed bytes not yet seen on the output

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int take_cyc = 0;
    int beat_cyc = 0;
    int beats = 0;
    int consumed = 0;
    int gap_pct = 0;
    int rdy_pct = 100;
    int long_gap = 0;
    bit rand_mode = 0;
    bit hold_pend = 0;
    logic [36:0] hold_word;
    logic [31:0] last_dat;
    logic [3:0]  last_keep;
    logic        last_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic l);
        src_q.push_back({l, b});
    endtask

    task automatic drive_inputs();
        bit gap;
        gap = 0;
        if (rand_mode && long_gap == 0 && $urandom_range(299) == 0) long_gap = 20;
        if (long_gap > 0) begin
            gap = 1;
            long_gap--;
        end else if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            gap = 1;
        end
        if (src_q.size() == 0 || gap) begin
            r_empty     = 1'b1;
            i_from_fifo = 8'h00;
            i_last      = 1'b0;
        end else begin
            r_empty     = 1'b0;
            i_from_fifo = src_q[0][7:0];
            i_last      = src_q[0][8];
        end
        s_axis_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
    endtask

    // Reference: every beat carries the next n consumed bytes in lane order,
    // never crosses a packet end, and carries tlast iff its final byte ended a packet.
    task automatic score_beat();
        int n;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        inner;
        n = 0;
        for (int k = 0; k < BYTES; k++) if (s_axis_tkeep[k]) n++;
        ek = 4'((1 << n) - 1);
        chk("beat_keep_contiguous", s_axis_tkeep, ek);
        chk("beat_bytes_available", (n >= 1 && exp_q.size() >= n), 1);
        if (n >= 1 && exp_q.size() >= n) begin
            ed = '0;
            inner = 1'b0;
            for (int k = 0; k < n; k++) begin
                ed[8*k +: 8] = exp_q[k][7:0];
                if (k < n - 1 && exp_q[k][8]) inner = 1'b1;
            end
            chk("beat_data", s_axis_tdata, ed);
            chk("beat_last", s_axis_tlast, exp_q[n-1][8]);
            chk("beat_no_inner_last", inner, 1'b0);
            for (int k = 0; k < n; k++) void'(exp_q.pop_front());
        end
        beats++;
        beat_cyc  = cyc;
        last_dat  = s_axis_tdata;
        last_keep = s_axis_tkeep;
        last_last = s_axis_tlast;
    endtask

    // One clock: drive after the edge, observe at the falling edge.
    task automatic cycle();
        logic took;
        drive_inputs();
        @(negedge s_axis_aclk);
        took = r_req;
        if (r_empty) chk("req_while_empty", r_req, 1'b0);
        if (hold_pend) begin
            chk("hold_valid", s_axis_valid, 1'b1);
            chk("hold_payload", {s_axis_tlast, s_axis_tkeep, s_axis_tdata}, hold_word);
        end
        hold_pend = s_axis_valid && !s_axis_ready;
        hold_word = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (s_axis_valid && s_axis_ready) score_beat();
        @(posedge s_axis_aclk);
        cyc++;
        if (took && !r_empty && src_q.size() > 0) begin
            exp_q.push_back(src_q.pop_front());
            consumed++;
            take_cyc = cyc;
        end
        #1;
    endtask

    task automatic run_until_beats(input int target, input int bound, input string tag);
        int n;
        n = 0;
        while (beats < target && n < bound) begin
            cycle();
            n++;
        end
        chk(tag, beats, target);
    endtask

    initial begin
        int c0;
        int b0;
        int n;
        int delta;
        logic [7:0] rb;
        logic       rl;

        s_axis_reset_n = 1'b0;
        r_empty        = 1'b0;
        i_from_fifo    = 8'hA5;
        i_last         = 1'b0;
        s_axis_ready   = 1'b1;
        @(posedge s_axis_aclk);
        #1;
        chk("rst_valid", s_axis_valid, 1'b0);
        chk("rst_tdata", s_axis_tdata, 32'h0);
        chk("rst_tkeep", s_axis_tkeep, 4'h0);
        chk("rst_tlast", s_axis_tlast, 1'b0);
        chk("rst_req", r_req, 1'b0);
        chk("rst_level", o_level, 3'd0);
        @(posedge s_axis_aclk);
        #1;
        s_axis_reset_n = 1'b1;

        // Full word, no packet end.
        push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0); push_byte(8'h44, 0);
        run_until_beats(1, 20, "t1_beat_seen");
        chk("t1_tdata", last_dat, 32'h44332211);
        chk("t1_tkeep", last_keep, 4'hF);
        chk("t1_tlast", last_last, 1'b0);
        chk("t1_latency", beat_cyc, take_cyc);

        // Short packet ends early.
        push_byte(8'hAA, 0); push_byte(8'hBB, 1);
        run_until_beats(2, 20, "t2_beat_seen");
        chk("t2_tdata", last_dat, 32'h0000BBAA);
        chk("t2_tkeep", last_keep, 4'h3);
        chk("t2_tlast", last_last, 1'b1);

        // Lone byte flushed after the idle timeout; the next byte restarts at lane 0.
        push_byte(8'h5A, 0);
        run_until_beats(3, 40, "t3_flush_seen");
        delta = beat_cyc - take_cyc;
        chk("t3_flush_delay", (delta >= FLUSH_TIMEOUT && delta <= FLUSH_TIMEOUT + 1), 1);
        chk("t3_tdata", last_dat, 32'h0000005A);
        chk("t3_tkeep", last_keep, 4'h1);
        chk("t3_tlast", last_last, 1'b0);
        push_byte(8'h77, 1);
        run_until_beats(4, 20, "t3_next_seen");
        chk("t3_next_tdata", last_dat, 32'h00000077);
        chk("t3_next_tkeep", last_keep, 4'h1);
        chk("t3_next_tlast", last_last, 1'b1);

        // Stalled downstream: buffer fills, consumption stops, then drains in order.
        rdy_pct = 0;
        c0 = consumed;
        b0 = beats;
        for (int i = 0; i < 20; i++) push_byte(8'(8'h30 + i), 0);
        for (int i = 0; i < 30; i++) cycle();
        chk("t4_level_full", o_level, 3'd4);
        chk("t4_req_low", r_req, 1'b0);
        chk("t4_consumed", consumed - c0, 16);
        rdy_pct = 100;
        run_until_beats(b0 + 5, 40, "t4_drain");
        chk("t4_all_consumed", consumed - c0, 20);
        chk("t4_nothing_left", exp_q.size(), 0);

        // Reset with two buffered words and a partial word in flight.
        rdy_pct = 0;
        c0 = consumed;
        for (int i = 0; i < 10; i++) push_byte(8'(8'h80 + i), 0);
        n = 0;
        while (consumed - c0 < 10 && n < 30) begin
            cycle();
            n++;
        end
        chk("t5_consumed", consumed - c0, 10);
        chk("t5_level", o_level, 3'd2);
        r_empty = 1'b0;
        i_from_fifo = 8'hEE;
        s_axis_reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", s_axis_valid, 1'b0);
        chk("t5_rst_tdata", s_axis_tdata, 32'h0);
        chk("t5_rst_tkeep", s_axis_tkeep, 4'h0);
        chk("t5_rst_tlast", s_axis_tlast, 1'b0);
        chk("t5_rst_req", r_req, 1'b0);
        chk("t5_rst_level", o_level, 3'd0);
        src_q.delete();
        exp_q.delete();
        hold_pend = 0;
        for (int i = 0; i < 3; i++) cycle();
        s_axis_reset_n = 1'b1;
        rdy_pct = 100;
        b0 = beats;
        push_byte(8'h01, 0); push_byte(8'h02, 0); push_byte(8'h03, 0); push_byte(8'h04, 0);
        run_until_beats(b0 + 1, 20, "t5_after_seen");
        chk("t5_after_tdata", last_dat, 32'h04030201);
        chk("t5_after_tkeep", last_keep, 4'hF);

        // Random gaps, random ready, random packet ends.
        for (int i = 0; i < 10000; i++) begin
            rb = 8'($urandom_range(255));
            rl = ($urandom_range(7) == 0);
            push_byte(rb, rl);
        end
        rand_mode = 1;
        gap_pct = 30;
        rdy_pct = 70;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < 60000) begin
            cycle();
            n++;
        end
        chk("t6_source_drained", src_q.size(), 0);
        chk("t6_output_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
